alu_seq_param: RTL and testbench

//   Parametrised sequential ALU with registered result/flags and valid/ready handshakes on input and output.

---
 rtl/alu_seq_pkg.sv | 34 +++
 rtl/alu_comb_core.sv | 63 ++++++
 rtl/alu_seq_param.sv | 192 +++++++++++++++++++
 tb/tb_alu_seq_param.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_seq_pkg.sv
// ----------------------------------------------------------------------------
// alu_seq_pkg
//   Shared opcode and FSM-state encodings for the sequential ALU.
//   op_e    : 4-bit opcode space; 12-15 are reserved and have no enumerator.
//   state_e : IDLE (accepting), RUN (multi-cycle iteration), DONE (result held).
// ----------------------------------------------------------------------------
package alu_seq_pkg;

    typedef enum logic [3:0] {
        OP_ADD = 4'd0,
        OP_SUB = 4'd1,
        OP_NOT = 4'd2,
        OP_AND = 4'd3,
        OP_OR  = 4'd4,
        OP_XOR = 4'd5,
        OP_SLT = 4'd6,
        OP_EQ  = 4'd7,
        OP_SLL = 4'd8,
        OP_SRL = 4'd9,
        OP_SRA = 4'd10,
        OP_MUL = 4'd11
    } op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    function automatic logic is_shift_op(input logic [3:0] op);
        return (op == OP_SLL) || (op == OP_SRL) || (op == OP_SRA);
    endfunction

endpackage

// File: rtl/alu_comb_core.sv
// ----------------------------------------------------------------------------
// alu_comb_core
//   Purely combinational part of the ALU: single-cycle ops 0-7 and the
//   reserved codes 12-15 (all-zero outputs). Shift/MUL codes also yield zeros
//   here; the top handles them iteratively.
// Ports:
//   op       in  4      opcode
//   a, b     in  WIDTH  operands
//   result   out WIDTH  op result
//   carry    out 1      carry-out (ADD) / no-borrow (SUB), else 0
//   overflow out 1      signed overflow (ADD/SUB), else 0
// ----------------------------------------------------------------------------
module alu_comb_core
    import alu_seq_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] result,
    output logic             carry,
    output logic             overflow
);

    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] b_inv;

    always_comb begin
        result   = '0;
        carry    = 1'b0;
        overflow = 1'b0;
        b_inv    = ~b;
        sum      = '0;
        case (op)
            OP_ADD: begin
                sum      = {1'b0, a} + {1'b0, b};
                result   = sum[WIDTH-1:0];
                carry    = sum[WIDTH];
                overflow = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB: begin
                // Two's-complement subtract; carry=1 means no borrow.
                sum      = {1'b0, a} + {1'b0, b_inv} + (WIDTH+1)'(1);
                result   = sum[WIDTH-1:0];
                carry    = sum[WIDTH];
                overflow = (a[WIDTH-1] == b_inv[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
            end
            OP_NOT: result = ~b;
            OP_AND: result = a & b;
            OP_OR:  result = a | b;
            OP_XOR: result = a ^ b;
            OP_SLT: result = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            OP_EQ:  result = {{(WIDTH-1){1'b0}}, (a == b)};
            default: begin
                result   = '0;
                carry    = 1'b0;
                overflow = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/alu_seq_param.sv
// ----------------------------------------------------------------------------
// alu_seq_param
//   Sequential ALU with valid/ready handshakes on both sides. Single-cycle ops
//   complete on the accept edge; shifts iterate one bit per RUN cycle and MUL
//   is a WIDTH-cycle unsigned shift-add. Result/flags are registered and only
//   change on entry to DONE.
// Ports:
//   clk, rst_n          clock (rising edge), async active-low reset
//   in_valid/in_ready   operand handshake (in_ready only in IDLE)
//   op, a, b            opcode and operands, captured on accept
//   out_valid/out_ready result handshake (out_valid only in DONE)
//   result, carry,      registered result and flags
//   overflow, zero
// ----------------------------------------------------------------------------
module alu_seq_param
    import alu_seq_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             carry,
    output logic             overflow,
    output logic             zero
);

    localparam int SHW = $clog2(WIDTH);
    localparam logic [SHW:0] MUL_ITER = (SHW+1)'(WIDTH);

    state_e             state_q;
    logic [SHW:0]       cnt_q;
    logic [WIDTH-1:0]   result_q;
    logic               carry_q;
    logic               overflow_q;
    logic               zero_q;

    logic [3:0]         op_q;
    logic [WIDTH-1:0]   sh_q;
    logic [2*WIDTH-1:0] prod_q;
    logic [2*WIDTH-1:0] mcand_q;
    logic [WIDTH-1:0]   mplier_q;

    logic               accept;
    logic [SHW-1:0]     k_in;
    logic               shift_in;
    logic [WIDTH-1:0]   core_res;
    logic               core_c;
    logic               core_ov;

    logic [WIDTH-1:0]   sh_nxt;
    logic               sh_out;
    logic [2*WIDTH-1:0] prod_nxt;
    logic [WIDTH-1:0]   fin_res;
    logic               fin_c;
    logic               last_iter;

    assign in_ready  = (state_q == IDLE) && rst_n;
    assign out_valid = (state_q == DONE);
    assign accept    = in_valid && in_ready;
    assign k_in      = b[SHW-1:0];
    assign shift_in  = is_shift_op(op);
    assign last_iter = (cnt_q == (SHW+1)'(1));

    assign result   = result_q;
    assign carry    = carry_q;
    assign overflow = overflow_q;
    assign zero     = zero_q;

    alu_comb_core #(.WIDTH(WIDTH)) u_core (
        .op       (op),
        .a        (a),
        .b        (b),
        .result   (core_res),
        .carry    (core_c),
        .overflow (core_ov)
    );

    // One iteration step of the shifter and multiplier, plus the value that
    // lands in the output registers when the last iteration retires.
    always_comb begin
        sh_nxt = sh_q;
        sh_out = 1'b0;
        case (op_q)
            OP_SLL: begin
                sh_nxt = {sh_q[WIDTH-2:0], 1'b0};
                sh_out = sh_q[WIDTH-1];
            end
            OP_SRL: begin
                sh_nxt = {1'b0, sh_q[WIDTH-1:1]};
                sh_out = sh_q[0];
            end
            OP_SRA: begin
                sh_nxt = {sh_q[WIDTH-1], sh_q[WIDTH-1:1]};
                sh_out = sh_q[0];
            end
            default: begin
                sh_nxt = sh_q;
                sh_out = 1'b0;
            end
        endcase

        prod_nxt = prod_q + (mplier_q[0] ? mcand_q : '0);

        if (op_q == OP_MUL) begin
            fin_res = prod_nxt[WIDTH-1:0];
            fin_c   = |prod_nxt[2*WIDTH-1:WIDTH];
        end else begin
            fin_res = sh_nxt;
            fin_c   = sh_out;
        end
    end

    // Control and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            result_q   <= '0;
            carry_q    <= 1'b0;
            overflow_q <= 1'b0;
            zero_q     <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        if (shift_in && (k_in != '0)) begin
                            state_q <= RUN;
                            cnt_q   <= {1'b0, k_in};
                        end else if (op == OP_MUL) begin
                            state_q <= RUN;
                            cnt_q   <= MUL_ITER;
                        end else if (shift_in) begin
                            // Zero-length shift passes A through unchanged.
                            state_q    <= DONE;
                            result_q   <= a;
                            carry_q    <= 1'b0;
                            overflow_q <= 1'b0;
                            zero_q     <= ~|a;
                        end else begin
                            state_q    <= DONE;
                            result_q   <= core_res;
                            carry_q    <= core_c;
                            overflow_q <= core_ov;
                            zero_q     <= ~|core_res;
                        end
                    end
                end
                RUN: begin
                    cnt_q <= cnt_q - (SHW+1)'(1);
                    if (last_iter) begin
                        state_q    <= DONE;
                        result_q   <= fin_res;
                        carry_q    <= fin_c;
                        overflow_q <= 1'b0;
                        zero_q     <= ~|fin_res;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Operand / iteration datapath: loaded on accept, stepped in RUN.
    always_ff @(posedge clk) begin
        if (accept) begin
            op_q     <= op;
            sh_q     <= a;
            prod_q   <= '0;
            mcand_q  <= {{WIDTH{1'b0}}, a};
            mplier_q <= b;
        end else if (state_q == RUN) begin
            sh_q     <= sh_nxt;
            prod_q   <= prod_nxt;
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
        end
    end

endmodule

// File: tb/tb_alu_seq_param.sv
// ----------------------------------------------------------------------------
// tb_alu_seq_param
//   Self-checking bench for alu_seq_param (WIDTH=8): directed cases, handshake
//   backpressure, reset abort during MUL, then randomized ops against an
//   arithmetic reference model.
// ----------------------------------------------------------------------------
module tb_alu_seq_param;

    localparam int W   = 8;
    localparam int SHW = 3;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [3:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] result;
    logic         carry;
    logic         overflow;
    logic         zero;

    int total  = 0;
    int passed = 0;

    alu_seq_param #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .carry     (carry),
        .overflow  (overflow),
        .zero      (zero)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not reach its summary");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // Reference: results from plain integer arithmetic on the operand values.
    task automatic model(input logic [3:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                         output logic [W-1:0] r, output logic c, output logic ov, output int lat);
        int sx, sy, s, k, p;
        sx  = $signed(x);
        sy  = $signed(y);
        k   = int'(y[SHW-1:0]);
        r   = '0;
        c   = 1'b0;
        ov  = 1'b0;
        lat = 1;
        case (o)
            4'd0: begin
                s  = int'(x) + int'(y);
                r  = W'(s);
                c  = (s > 255);
                ov = ((sx + sy) > 127) || ((sx + sy) < -128);
            end
            4'd1: begin
                s  = int'(x) - int'(y);
                r  = W'(s);
                c  = (x >= y);
                ov = ((sx - sy) > 127) || ((sx - sy) < -128);
            end
            4'd2: r = ~y;
            4'd3: r = x & y;
            4'd4: r = x | y;
            4'd5: r = x ^ y;
            4'd6: r = (sx < sy) ? W'(1) : W'(0);
            4'd7: r = (x == y) ? W'(1) : W'(0);
            4'd8: begin
                r   = W'(int'(x) << k);
                if (k > 0) c = x[W-k];
                lat = k + 1;
            end
            4'd9: begin
                r   = W'(int'(x) >> k);
                if (k > 0) c = x[k-1];
                lat = k + 1;
            end
            4'd10: begin
                r   = W'(sx >>> k);
                if (k > 0) c = x[k-1];
                lat = k + 1;
            end
            4'd11: begin
                p   = int'(x) * int'(y);
                r   = W'(p);
                c   = ((p >> W) != 0);
                lat = W + 1;
            end
            default: begin
                r = '0;
            end
        endcase
    endtask

    // Called at a negedge with out_ready=1; returns at a negedge in IDLE.
    task automatic run_op(input logic [3:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
        logic [W-1:0] er;
        logic         ec;
        logic         eov;
        int           elat;
        int           lat;
        string        t;
        model(o, x, y, er, ec, eov, elat);
        t = $sformatf("op%0d_%02h_%02h", o, x, y);
        check({t, "_in_ready"}, 16'(in_ready), 16'(1));
        op       = o;
        a        = x;
        b        = y;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        op       = 4'($urandom);
        a        = W'($urandom);
        b        = W'($urandom);
        lat      = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (out_valid !== 1'b1 && lat < 40);
        check({t, "_latency"}, 16'(lat), 16'(elat));
        check({t, "_result"}, 16'(result), 16'(er));
        check({t, "_carry"}, 16'(carry), 16'(ec));
        check({t, "_overflow"}, 16'(overflow), 16'(eov));
        check({t, "_zero"}, 16'(zero), 16'(er == '0));
        @(negedge clk);
        check({t, "_back_idle"}, 16'({out_valid, in_ready}), 16'(2'b01));
    endtask

    initial begin
        int seen;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        op        = 4'd0;
        a         = '0;
        b         = '0;
        repeat (2) @(negedge clk);
        check("reset_result", 16'(result), 16'(0));
        check("reset_flags", 16'({carry, overflow, zero}), 16'(0));
        check("reset_out_valid", 16'(out_valid), 16'(0));
        rst_n = 1'b1;
        @(negedge clk);

        // Directed cases
        run_op(4'd0,  8'h7F, 8'h01);
        run_op(4'd1,  8'h05, 8'h05);
        run_op(4'd6,  8'hFF, 8'h01);
        run_op(4'd7,  8'h3C, 8'h3C);
        run_op(4'd10, 8'h80, 8'h03);
        run_op(4'd8,  8'h81, 8'h01);
        run_op(4'd9,  8'hA5, 8'h00);
        run_op(4'd11, 8'h0F, 8'h11);
        run_op(4'd11, 8'h10, 8'h10);
        run_op(4'd13, 8'h12, 8'h34);
        run_op(4'd8,  8'hC3, 8'h07);

        // Backpressure: hold DONE for 5 cycles while offering a new op
        out_ready = 1'b0;
        op        = 4'd0;
        a         = 8'h7F;
        b         = 8'h01;
        in_valid  = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(negedge clk);
        check("bp_first_valid", 16'(out_valid), 16'(1));
        for (int i = 0; i < 5; i++) begin
            op       = 4'd1;
            a        = 8'h11;
            b        = 8'h22;
            in_valid = 1'b1;
            @(negedge clk);
            check("bp_hold_result", 16'(result), 16'(8'h80));
            check("bp_hold_flags", 16'({carry, overflow, zero}), 16'(3'b010));
            check("bp_hold_hs", 16'({out_valid, in_ready}), 16'(2'b10));
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        check("bp_release_hs", 16'({out_valid, in_ready}), 16'(2'b01));
        check("bp_idle_result", 16'(result), 16'(8'h80));
        @(negedge clk);
        check("bp_idle_stable", 16'({result, carry, overflow, zero}), 16'({8'h80, 3'b010}));

        // Reset three cycles into a MUL
        op       = 4'd11;
        a        = 8'h0F;
        b        = 8'h11;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort_result", 16'(result), 16'(0));
        check("abort_flags", 16'({carry, overflow, zero}), 16'(0));
        check("abort_out_valid", 16'(out_valid), 16'(0));
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        seen  = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (out_valid === 1'b1) seen++;
        end
        check("abort_no_valid", 16'(seen), 16'(0));
        run_op(4'd0, 8'h01, 8'h02);

        // Randomized ops over the full opcode space
        for (int n = 0; n < 60; n++) begin
            run_op(4'($urandom_range(15, 0)), W'($urandom), W'($urandom));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
